parity_stream_merge_arbiter: RTL and testbench

- Recombines the odd-parity and even-parity AXI-Stream outputs of the parity filter into one downstream AXI-Stream.
- Arbitrates at packet granularity (tlast-delimited) with round-robin fairness.
- Tags each beat with its source stream and keeps per-source packet counters for status readout.
- Sits between the parity filter master ports and the single shared downstream consumer.

---
 rtl/parity_stream_merge_arbiter.sv | 143 ++++++++++++++
 tb/tb_parity_stream_merge_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_merge_arbiter.sv
// -----------------------------------------------------------------------------
// parity_stream_merge_arbiter
//
// Merges the odd-parity and even-parity AXI-Stream outputs of the parity filter
// into one downstream AXI-Stream. Arbitration happens per packet (tlast
// delimited) with round-robin fairness between the two sources. While a stream
// holds the grant, its beats pass through combinationally with no added
// latency. Each beat is tagged with its source, and a packet counter per source
// is kept for status readout.
//
// Ports
//   a_clk                 single clock; all logic runs on the rising edge
//   axis_areset           asynchronous, active-high reset
//   cfg_enable            1 = new grants allowed, 0 = no new packet is started
//   axis_s_*_odd          odd-parity slave stream (tvalid/tdata/tlast/tready)
//   axis_s_*_even         even-parity slave stream (tvalid/tdata/tlast/tready)
//   axis_m_tvalid/tdata/tlast/tready   merged master stream
//   axis_m_tsrc           source of the current beat: 1 = odd, 0 = even
//   busy                  high while a stream holds the grant
//   pkt_cnt_odd/even      packets forwarded per source; wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module parity_stream_merge_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              a_clk,
  input  logic              axis_areset,
  input  logic              cfg_enable,

  input  logic              axis_s_tvalid_odd,
  input  logic [DATA_W-1:0] axis_s_tdata_odd,
  input  logic              axis_s_tlast_odd,
  output logic              axis_s_tready_odd,

  input  logic              axis_s_tvalid_even,
  input  logic [DATA_W-1:0] axis_s_tdata_even,
  input  logic              axis_s_tlast_even,
  output logic              axis_s_tready_even,

  output logic              axis_m_tvalid,
  output logic [DATA_W-1:0] axis_m_tdata,
  output logic              axis_m_tlast,
  output logic              axis_m_tsrc,
  input  logic              axis_m_tready,

  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt_odd,
  output logic [CNT_W-1:0]  pkt_cnt_even
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_ODD  = 2'd1,
    GRANT_EVEN = 2'd2
  } state_t;

  // last_grant encoding matches axis_m_tsrc: 1 = odd, 0 = even.
  localparam logic SRC_ODD  = 1'b1;
  localparam logic SRC_EVEN = 1'b0;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   inc_odd, inc_even;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; mixing in blocking writes creates order races.
  always_ff @(posedge a_clk or posedge axis_areset) begin
    if (axis_areset) begin
      state        <= IDLE;
      last_grant   <= SRC_EVEN;   // odd wins the first tie after reset
      pkt_cnt_odd  <= '0;
      pkt_cnt_even <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (inc_odd)  pkt_cnt_odd  <= pkt_cnt_odd  + 1'b1;
      if (inc_even) pkt_cnt_even <= pkt_cnt_even + 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt          = state;
    last_grant_nxt     = last_grant;
    inc_odd            = 1'b0;
    inc_even           = 1'b0;
    axis_s_tready_odd  = 1'b0;
    axis_s_tready_even = 1'b0;
    axis_m_tvalid      = 1'b0;
    axis_m_tdata       = '0;
    axis_m_tlast       = 1'b0;
    axis_m_tsrc        = 1'b0;
    busy               = 1'b0;

    unique case (state)
      IDLE: begin
        if (cfg_enable && (axis_s_tvalid_odd || axis_s_tvalid_even)) begin
          // Odd is taken when it is the only requester, or on a tie when even
          // was served last; every other case goes to even.
          if (axis_s_tvalid_odd && (!axis_s_tvalid_even || last_grant == SRC_EVEN)) begin
            state_nxt      = GRANT_ODD;
            last_grant_nxt = SRC_ODD;
          end else begin
            state_nxt      = GRANT_EVEN;
            last_grant_nxt = SRC_EVEN;
          end
        end
      end

      GRANT_ODD: begin
        busy              = 1'b1;
        axis_m_tvalid     = axis_s_tvalid_odd;
        axis_m_tdata      = axis_s_tdata_odd;
        axis_m_tlast      = axis_s_tlast_odd;
        axis_m_tsrc       = SRC_ODD;
        // Ready is driven from downstream ready only, never from valid, so no
        // combinational loop forms through this block.
        axis_s_tready_odd = axis_m_tready;
        if (axis_s_tvalid_odd && axis_m_tready && axis_s_tlast_odd) begin
          inc_odd   = 1'b1;
          state_nxt = IDLE;
        end
      end

      GRANT_EVEN: begin
        busy               = 1'b1;
        axis_m_tvalid      = axis_s_tvalid_even;
        axis_m_tdata       = axis_s_tdata_even;
        axis_m_tlast       = axis_s_tlast_even;
        axis_m_tsrc        = SRC_EVEN;
        axis_s_tready_even = axis_m_tready;
        if (axis_s_tvalid_even && axis_m_tready && axis_s_tlast_even) begin
          inc_even  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parity_stream_merge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parity_stream_merge_arbiter
//
// Directed bench for parity_stream_merge_arbiter. Source models feed beats
// from queues; every expected output beat is pushed to a scoreboard when the
// stimulus is loaded, and a monitor on the falling edge pops and compares each
// accepted downstream beat. The monitor also checks beat stability under
// backpressure, ready routing while granted and all-zero outputs while idle.
// -----------------------------------------------------------------------------
module tb_parity_stream_merge_arbiter;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              src;
  } beat_t;

  logic              a_clk = 1'b0;
  logic              axis_areset;
  logic              cfg_enable;
  logic              axis_s_tvalid_odd;
  logic [DATA_W-1:0] axis_s_tdata_odd;
  logic              axis_s_tlast_odd;
  logic              axis_s_tready_odd;
  logic              axis_s_tvalid_even;
  logic [DATA_W-1:0] axis_s_tdata_even;
  logic              axis_s_tlast_even;
  logic              axis_s_tready_even;
  logic              axis_m_tvalid;
  logic [DATA_W-1:0] axis_m_tdata;
  logic              axis_m_tlast;
  logic              axis_m_tsrc;
  logic              axis_m_tready;
  logic              busy;
  logic [CNT_W-1:0]  pkt_cnt_odd;
  logic [CNT_W-1:0]  pkt_cnt_even;

  parity_stream_merge_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .a_clk              (a_clk),
    .axis_areset        (axis_areset),
    .cfg_enable         (cfg_enable),
    .axis_s_tvalid_odd  (axis_s_tvalid_odd),
    .axis_s_tdata_odd   (axis_s_tdata_odd),
    .axis_s_tlast_odd   (axis_s_tlast_odd),
    .axis_s_tready_odd  (axis_s_tready_odd),
    .axis_s_tvalid_even (axis_s_tvalid_even),
    .axis_s_tdata_even  (axis_s_tdata_even),
    .axis_s_tlast_even  (axis_s_tlast_even),
    .axis_s_tready_even (axis_s_tready_even),
    .axis_m_tvalid      (axis_m_tvalid),
    .axis_m_tdata       (axis_m_tdata),
    .axis_m_tlast       (axis_m_tlast),
    .axis_m_tsrc        (axis_m_tsrc),
    .axis_m_tready      (axis_m_tready),
    .busy               (busy),
    .pkt_cnt_odd        (pkt_cnt_odd),
    .pkt_cnt_even       (pkt_cnt_even)
  );

  always #5 a_clk = ~a_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  beat_t src_odd_q[$];
  beat_t src_even_q[$];
  beat_t exp_q[$];
  bit    rdy_q[$];
  int    beat_cyc_q[$];

  bit    fire_odd, fire_even;
  bit    prev_stall;
  beat_t prev_beat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge a_clk) cyc++;

  // Source and downstream-ready driver: updates inputs 1 time unit after each
  // rising edge, retiring source beats that handshook in the previous cycle.
  initial begin
    forever begin
      @(posedge a_clk);
      #1;
      if (fire_odd  && src_odd_q.size()  > 0) void'(src_odd_q.pop_front());
      if (fire_even && src_even_q.size() > 0) void'(src_even_q.pop_front());
      fire_odd  = 1'b0;
      fire_even = 1'b0;
      axis_m_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      axis_s_tvalid_odd  = (src_odd_q.size() > 0);
      axis_s_tdata_odd   = (src_odd_q.size() > 0) ? src_odd_q[0].data : '0;
      axis_s_tlast_odd   = (src_odd_q.size() > 0) ? src_odd_q[0].last : 1'b0;
      axis_s_tvalid_even = (src_even_q.size() > 0);
      axis_s_tdata_even  = (src_even_q.size() > 0) ? src_even_q[0].data : '0;
      axis_s_tlast_even  = (src_even_q.size() > 0) ? src_even_q[0].last : 1'b0;
    end
  end

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge a_clk) begin
    beat_t cur;
    cur = '{data: axis_m_tdata, last: axis_m_tlast, src: axis_m_tsrc};
    fire_odd  = axis_s_tvalid_odd  && axis_s_tready_odd;
    fire_even = axis_s_tvalid_even && axis_s_tready_even;
    if (axis_areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(axis_m_tvalid), 32'd1);
        check("stall_beat_held", 32'(cur), 32'(prev_beat));
      end
      if (busy) begin
        if (axis_m_tsrc) begin
          check("odd_ready_mirrors", 32'(axis_s_tready_odd), 32'(axis_m_tready));
          check("even_ready_blocked", 32'(axis_s_tready_even), 32'd0);
        end else begin
          check("even_ready_mirrors", 32'(axis_s_tready_even), 32'(axis_m_tready));
          check("odd_ready_blocked", 32'(axis_s_tready_odd), 32'd0);
        end
      end else begin
        check("idle_outputs_zero",
              32'({axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tsrc,
                   axis_s_tready_odd, axis_s_tready_even}), 32'd0);
      end
      if (axis_m_tvalid && axis_m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data 0x%0h src %0d, expected no beat", axis_m_tdata, axis_m_tsrc);
        end else begin
          check("beat", 32'(cur), 32'(exp_q.pop_front()));
        end
        beat_cyc_q.push_back(cyc);
      end
      prev_stall = axis_m_tvalid && !axis_m_tready;
      prev_beat  = cur;
    end
  end

  task automatic add_src(input bit odd, input logic [7:0] data, input bit last);
    beat_t b;
    b = '{data: data, last: last, src: odd};
    if (odd) src_odd_q.push_back(b);
    else     src_even_q.push_back(b);
  endtask

  task automatic add_exp(input bit odd, input logic [7:0] data, input bit last);
    exp_q.push_back('{data: data, last: last, src: odd});
  endtask

  task automatic add_beat(input bit odd, input logic [7:0] data, input bit last);
    add_src(odd, data, last);
    add_exp(odd, data, last);
  endtask

  // Waits until all expected beats are seen and the arbiter is idle (and the
  // sources drained when need_src is set); a blown budget counts as a failure.
  task automatic wait_done(input string name, input int budget, input bit need_src);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy &&
             (!need_src || (src_odd_q.size() == 0 && src_even_q.size() == 0)))
           && n < budget) begin
      @(posedge a_clk);
      #2;
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d beats outstanding after %0d cycles, expected 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic apply_reset();
    @(posedge a_clk);
    #3;
    axis_areset = 1'b1;
    src_odd_q.delete();
    src_even_q.delete();
    exp_q.delete();
    rdy_q.delete();
    repeat (2) @(posedge a_clk);
    #2;
    axis_areset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_m_tvalid"},   32'(axis_m_tvalid), 32'd0);
    check({tag, "_m_tdata"},    32'(axis_m_tdata), 32'd0);
    check({tag, "_m_tlast"},    32'(axis_m_tlast), 32'd0);
    check({tag, "_m_tsrc"},     32'(axis_m_tsrc), 32'd0);
    check({tag, "_tready_odd"}, 32'(axis_s_tready_odd), 32'd0);
    check({tag, "_tready_even"},32'(axis_s_tready_even), 32'd0);
    check({tag, "_cnt_odd"},    32'(pkt_cnt_odd), 32'd0);
    check({tag, "_cnt_even"},   32'(pkt_cnt_even), 32'd0);
  endtask

  initial begin
    axis_areset        = 1'b1;
    cfg_enable         = 1'b0;
    axis_m_tready      = 1'b1;
    axis_s_tvalid_odd  = 1'b0;
    axis_s_tdata_odd   = '0;
    axis_s_tlast_odd   = 1'b0;
    axis_s_tvalid_even = 1'b0;
    axis_s_tdata_even  = '0;
    axis_s_tlast_even  = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge a_clk);
    #2;
    axis_areset = 1'b0;
    cfg_enable  = 1'b1;

    // Odd-only 3-beat packet.
    add_beat(1'b1, 8'h01, 1'b0);
    add_beat(1'b1, 8'h03, 1'b0);
    add_beat(1'b1, 8'h05, 1'b1);
    wait_done("odd_only", 20, 1'b1);
    check("odd_only_cnt_odd", 32'(pkt_cnt_odd), 32'd1);
    check("odd_only_busy_low", 32'(busy), 32'd0);

    // Tie from reset: odd first, one bubble, then even; a second tie is odd again.
    apply_reset();
    beat_cyc_q.delete();
    add_beat(1'b1, 8'h11, 1'b0);
    add_beat(1'b1, 8'h13, 1'b1);
    add_beat(1'b0, 8'h22, 1'b0);
    add_beat(1'b0, 8'h24, 1'b1);
    wait_done("tie1", 30, 1'b1);
    check("tie1_beats_back_to_back", 32'(beat_cyc_q[1] - beat_cyc_q[0]), 32'd1);
    check("tie1_one_bubble", 32'(beat_cyc_q[2] - beat_cyc_q[1]), 32'd2);
    check("tie1_cnt_odd", 32'(pkt_cnt_odd), 32'd1);
    check("tie1_cnt_even", 32'(pkt_cnt_even), 32'd1);
    add_beat(1'b1, 8'h15, 1'b0);
    add_beat(1'b1, 8'h17, 1'b1);
    add_beat(1'b0, 8'h26, 1'b0);
    add_beat(1'b0, 8'h28, 1'b1);
    wait_done("tie2", 30, 1'b1);
    check("tie2_cnt_odd", 32'(pkt_cnt_odd), 32'd2);
    check("tie2_cnt_even", 32'(pkt_cnt_even), 32'd2);

    // Backpressure on a 4-beat even packet; odd requests mid-packet and must
    // wait. Ready pattern index 0 falls in the IDLE decision cycle.
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    add_beat(1'b0, 8'h30, 1'b0);
    add_beat(1'b0, 8'h32, 1'b0);
    add_beat(1'b0, 8'h34, 1'b0);
    add_beat(1'b0, 8'h36, 1'b1);
    begin
      int n;
      n = 0;
      while (!busy && n < 10) begin
        @(posedge a_clk);
        #2;
        n++;
      end
      check("bp_granted", 32'(busy), 32'd1);
    end
    add_beat(1'b1, 8'h3f, 1'b1);
    wait_done("backpressure", 40, 1'b1);
    check("bp_cnt_even", 32'(pkt_cnt_even), 32'd3);
    check("bp_cnt_odd", 32'(pkt_cnt_odd), 32'd3);

    // Enable gating.
    cfg_enable = 1'b0;
    add_src(1'b1, 8'h41, 1'b0);
    add_src(1'b1, 8'h43, 1'b0);
    add_src(1'b1, 8'h45, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge a_clk);
      #2;
      check("gated_no_grant", 32'(busy), 32'd0);
    end
    add_exp(1'b1, 8'h41, 1'b0);
    add_exp(1'b1, 8'h43, 1'b0);
    add_exp(1'b1, 8'h45, 1'b1);
    cfg_enable = 1'b1;
    @(posedge a_clk);
    #2;
    check("enable_grant_next_edge", 32'({busy, axis_m_tsrc}), 32'b11);
    cfg_enable = 1'b0;
    add_src(1'b1, 8'h47, 1'b0);
    add_src(1'b1, 8'h49, 1'b1);
    wait_done("enable_drop", 20, 1'b0);
    check("enable_drop_cnt_odd", 32'(pkt_cnt_odd), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge a_clk);
      #2;
      check("disabled_stays_idle", 32'(busy), 32'd0);
    end
    add_exp(1'b1, 8'h47, 1'b0);
    add_exp(1'b1, 8'h49, 1'b1);
    cfg_enable = 1'b1;
    wait_done("reenable", 20, 1'b1);
    check("reenable_cnt_odd", 32'(pkt_cnt_odd), 32'd5);

    // Reset in the middle of an odd packet.
    add_beat(1'b1, 8'h51, 1'b0);
    add_beat(1'b1, 8'h53, 1'b0);
    add_beat(1'b1, 8'h55, 1'b0);
    add_beat(1'b1, 8'h57, 1'b1);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 2 && n < 20) begin
        @(posedge a_clk);
        #2;
        n++;
      end
      check("mid_packet_busy", 32'(busy), 32'd1);
    end
    #1;
    axis_areset = 1'b1;
    src_odd_q.delete();
    src_even_q.delete();
    exp_q.delete();
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge a_clk);
    #2;
    axis_areset = 1'b0;

    // Counter wrap: 16 single-beat even packets on a 4-bit counter.
    for (int i = 0; i < 15; i++) add_beat(1'b0, 8'(8'h60 + i), 1'b1);
    wait_done("wrap15", 120, 1'b1);
    check("wrap_cnt_even_15", 32'(pkt_cnt_even), 32'd15);
    add_beat(1'b0, 8'h6f, 1'b1);
    wait_done("wrap16", 20, 1'b1);
    check("wrap_cnt_even_0", 32'(pkt_cnt_even), 32'd0);
    check("wrap_cnt_odd_0", 32'(pkt_cnt_odd), 32'd0);

    repeat (3) @(posedge a_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
